fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Instruction-fetch controller for the single-cycle-latency instruction memory.
- Owns the program counter and drives the memory's word-indexed address each cycle.
- Tracks the in-flight read and buffers returned words in a 2-entry queue.
- Presents instructions to decode over a valid/ready handshake; handles stall, branch redirect and end-of-program halt.

Parameters:
- RESET_PC, 0, word index of the first instruction fetched after start.
- PROG_WORDS, 7, number of valid memory words; fetch address >= PROG_WORDS ends the program.
- ADDR_STEP, 1, PC increment per issued fetch (memory is word-indexed).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse: leave IDLE/HALT and begin fetching at RESET_PC.
- stall  in  1  blocks issuing new fetches; does not block the output handshake.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  32  new word index when redirect_valid=1.
- mem_addr  out  32  address to memory (registered PC); memory samples it at each rising edge.
- mem_rdata  in  32  memory data, valid one cycle after the address was sampled.
- instr  out  32  instruction to decode (head of buffer).
- instr_pc  out  32  word index of instr.
- instr_valid  out  1  instr/instr_pc valid.
- instr_ready  in  1  decode accepts when instr_valid & instr_ready.
- busy  out  1  high in RUN and DRAIN.
- halted  out  1  high in HALT.

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0 and on release:
  - state=IDLE, pc=mem_addr=RESET_PC.
  - instr=0, instr_pc=0, instr_valid=0, busy=0, halted=0.
  - inflight=0, buffer count=0.
- Asserting rst_n=0 at any time, including mid-fetch, discards all in-flight and buffered data.
- States:
  - IDLE: start -> RUN; pc=RESET_PC.
  - RUN: issues fetches. When an issue would use pc >= PROG_WORDS, no issue -> DRAIN.
  - DRAIN: no issues. When inflight=0 and count=0 -> HALT.
  - HALT: halted=1. start -> RUN with pc=RESET_PC.
- Issue, evaluated in RUN only:
  - issue = !stall & !redirect_valid & (pc < PROG_WORDS) & (count + inflight - pop < 2).
  - pop = instr_valid & instr_ready.
  - On issue: inflight<=1, inflight_pc<=pc, pc<=pc+ADDR_STEP (32-bit wrap, no saturation).
  - Without issue: inflight<=0.
- Capture: when inflight=1, mem_rdata and inflight_pc are pushed into the buffer at the next edge.
- Latency: address sampled at edge N -> instr_valid=1 after edge N+1 if the buffer was empty.
- Sustained throughput: 1 instruction/cycle with instr_ready=1 and stall=0.
- Buffer rules:
  - Push and pop in the same cycle keep count unchanged.
  - Issue control guarantees no overflow; overflow is not possible and needs no handling.
  - instr/instr_pc must hold stable while instr_valid=1 and instr_ready=0.
- Redirect has the highest priority, over stall, start and pop, in RUN or DRAIN:
  - pc<=redirect_pc, buffer cleared (count<=0), inflight<=0.
  - The returning word is discarded; instr_valid=0 on the next cycle.
  - DRAIN + redirect with redirect_pc < PROG_WORDS -> RUN.
  - RUN or DRAIN + redirect with redirect_pc >= PROG_WORDS -> DRAIN, then HALT.
  - redirect_valid in IDLE or HALT is ignored.
- start in RUN or DRAIN is ignored.
- busy = (state==RUN)|(state==DRAIN); halted = (state==HALT).

Decomposition:
- Shared package fetch_pkg holds:
  - state enum (IDLE, RUN, DRAIN, HALT);
  - WORD_W=32;
  - the buffer-entry typedef {instr, pc}.
- Sub-module fetch_buffer: 2-entry synchronous FIFO with push/pop/flush, count, head outputs, same clk/rst_n.

Test Plan:
- Reset then start, instr_ready=1, memory words 0..6 = 0xA0..0xA6:
  - instr_pc 0..6 on 7 consecutive cycles, first valid 2 cycles after start;
  - then halted=1, busy=0, no further instr_valid.
- instr_ready=0 from the second instruction for 5 cycles:
  - instr_pc=1 held stable, count reaches 2, mem_addr frozen;
  - after release: pcs 1,2,3... with no loss or duplicate.
- stall=1 for 3 cycles mid-run: no new fetches; already issued word still delivered; resumes at next pc.
- redirect_valid=1, redirect_pc=5 while pcs 2 and 3 are buffered/in flight:
  - neither 2 nor 3 appears after the redirect;
  - next instr_pc=5, then 6, then HALT.
- Redirect to 9 (>= PROG_WORDS) in RUN: DRAIN, then HALT; no instr_valid after the redirect.
- rst_n=0 asynchronously mid-run with instr_valid=1:
  - instr_valid=0 and mem_addr=0 immediately, without a clock edge;
  - state IDLE; start restarts at pc 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types for the instruction-fetch slice.
//   state_t  : sequencer control states (IDLE, RUN, DRAIN, HALT)
//   WORD_W   : width of instruction words and word-index addresses
//   entry_t  : one buffered fetch result {instr, pc}
// ---------------------------------------------------------------------------
package fetch_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } state_t;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc;
  } entry_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// ---------------------------------------------------------------------------
// fetch_sequencer_if
// Bundles every non-clock signal of the fetch sequencer.
//   control  : start, stall, redirect_valid, redirect_pc
//   memory   : mem_addr (to memory), mem_rdata (from memory)
//   decode   : instr, instr_pc, instr_valid (to decode), instr_ready (from decode)
//   status   : busy, halted
// master = the fetch sequencer, slave = its surroundings (memory/decode/control).
// ---------------------------------------------------------------------------
interface fetch_sequencer_if;
  import fetch_pkg::*;

  logic              start;
  logic              stall;
  logic              redirect_valid;
  logic [WORD_W-1:0] redirect_pc;
  logic [WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_rdata;
  logic [WORD_W-1:0] instr;
  logic [WORD_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              busy;
  logic              halted;

  modport master (
    input  start, stall, redirect_valid, redirect_pc, mem_rdata, instr_ready,
    output mem_addr, instr, instr_pc, instr_valid, busy, halted
  );

  modport slave (
    output start, stall, redirect_valid, redirect_pc, mem_rdata, instr_ready,
    input  mem_addr, instr, instr_pc, instr_valid, busy, halted
  );

endinterface

// File: rtl/fetch_buffer.sv
// ---------------------------------------------------------------------------
// fetch_buffer
// Two-entry synchronous FIFO holding returned fetch words until decode takes them.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : write i_data at the tail
//   i_pop      : drop the head entry (ignored when empty)
//   i_flush    : discard all entries; wins over push and pop
//   i_data     : entry to write
//   o_head     : oldest entry (stable until popped or flushed)
//   o_count    : number of stored entries, 0..2
// ---------------------------------------------------------------------------
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic       i_flush,
  input  entry_t     i_data,
  output entry_t     o_head,
  output logic [1:0] o_count
);

  entry_t     r_entries [2];
  logic       r_rdPtr;
  logic       r_wrPtr;
  logic [1:0] r_count;

  logic       w_doPop;
  logic       w_doPush;

  // A pop only counts when something is stored; a push is accepted while there
  // is room, or when the head leaves in the same cycle.
  always_comb begin
    w_doPop  = i_pop & (r_count != 2'd0);
    w_doPush = i_push & ((r_count != 2'd2) | w_doPop);
  end

  // Storage, pointers and occupancy. Flush only resets the bookkeeping; stale
  // entry contents are never visible because count goes to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_entries[i] <= '0;
      end
      r_rdPtr <= 1'b0;
      r_wrPtr <= 1'b0;
      r_count <= 2'd0;
    end else if (i_flush) begin
      r_rdPtr <= 1'b0;
      r_wrPtr <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_doPush) begin
        r_entries[r_wrPtr] <= i_data;
        r_wrPtr            <= ~r_wrPtr;
      end
      if (w_doPop) begin
        r_rdPtr <= ~r_rdPtr;
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_entries[r_rdPtr];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
// Instruction-fetch controller for a single-cycle-latency, word-indexed
// instruction memory. Owns the PC, tracks one in-flight read, buffers returned
// words in a 2-entry FIFO and hands them to decode over valid/ready.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   fetchBus   : fetch_sequencer_if.master carrying control, memory, decode and
//                status signals
// Parameters:
//   RESET_PC   : first word index fetched after start
//   PROG_WORDS : number of valid memory words; fetching at or beyond it ends
//                the program
//   ADDR_STEP  : PC increment per issued fetch
// ---------------------------------------------------------------------------
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC   = '0,
  parameter int unsigned       PROG_WORDS = 7,
  parameter logic [WORD_W-1:0] ADDR_STEP  = 32'd1
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_sequencer_if.master  fetchBus
);

  localparam logic [WORD_W-1:0] PROG_LIMIT = WORD_W'(PROG_WORDS);

  state_t            r_state;
  logic [WORD_W-1:0] r_pc;
  logic              r_inflight;
  logic [WORD_W-1:0] r_inflightPc;

  state_t            w_nextState;
  logic [WORD_W-1:0] w_nextPc;
  logic              w_nextInflight;
  logic [WORD_W-1:0] w_nextInflightPc;
  logic              w_flush;
  logic              w_pop;
  logic              w_canIssue;
  logic [2:0]        w_occupancy;
  logic [1:0]        w_count;
  logic              w_instrValid;
  entry_t            w_head;
  entry_t            w_pushData;

  fetch_buffer u_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_inflight & ~w_flush),
    .i_pop   (w_pop & ~w_flush),
    .i_flush (w_flush),
    .i_data  (w_pushData),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // The word returning this cycle belongs to the address issued last cycle.
  assign w_pushData = '{instr: fetchBus.mem_rdata, pc: r_inflightPc};

  assign w_instrValid = (w_count != 2'd0);
  assign w_pop        = w_instrValid & fetchBus.instr_ready;

  // Issue only if, after this edge, buffered plus in-flight words still fit
  // in the two buffer slots: count + inflight - pop must stay below 2.
  always_comb begin
    w_occupancy = {1'b0, w_count} + {2'b0, r_inflight};
    w_canIssue  = ~fetchBus.stall & (w_occupancy < (3'd2 + {2'b0, w_pop}));
  end

  // Next-state and datapath control. Redirect dominates everything while the
  // sequencer is active; it drops the in-flight word and the buffer and jumps.
  always_comb begin
    w_nextState      = r_state;
    w_nextPc         = r_pc;
    w_nextInflight   = 1'b0;
    w_nextInflightPc = r_inflightPc;
    w_flush          = 1'b0;

    case (r_state)
      IDLE, HALT: begin
        if (fetchBus.start) begin
          w_nextState = RUN;
          w_nextPc    = RESET_PC;
        end
      end

      RUN: begin
        if (fetchBus.redirect_valid) begin
          w_flush     = 1'b1;
          w_nextPc    = fetchBus.redirect_pc;
          w_nextState = (fetchBus.redirect_pc < PROG_LIMIT) ? RUN : DRAIN;
        end else if (r_pc >= PROG_LIMIT) begin
          w_nextState = DRAIN;
        end else if (w_canIssue) begin
          w_nextInflight   = 1'b1;
          w_nextInflightPc = r_pc;
          w_nextPc         = r_pc + ADDR_STEP;
        end
      end

      DRAIN: begin
        if (fetchBus.redirect_valid) begin
          w_flush     = 1'b1;
          w_nextPc    = fetchBus.redirect_pc;
          w_nextState = (fetchBus.redirect_pc < PROG_LIMIT) ? RUN : DRAIN;
        end else if (!r_inflight && (w_count == 2'd0)) begin
          w_nextState = HALT;
        end
      end

      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Control state, PC and in-flight tracking registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_inflight   <= 1'b0;
      r_inflightPc <= '0;
    end else begin
      r_state      <= w_nextState;
      r_pc         <= w_nextPc;
      r_inflight   <= w_nextInflight;
      r_inflightPc <= w_nextInflightPc;
    end
  end

  // Decode sees zeros whenever nothing is valid, so reset and flush leave
  // clean outputs; while valid the head entry is held until popped.
  assign fetchBus.mem_addr    = r_pc;
  assign fetchBus.instr       = w_instrValid ? w_head.instr : '0;
  assign fetchBus.instr_pc    = w_instrValid ? w_head.pc    : '0;
  assign fetchBus.instr_valid = w_instrValid;
  assign fetchBus.busy        = (r_state == RUN) | (r_state == DRAIN);
  assign fetchBus.halted      = (r_state == HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
// Directed bench for fetch_sequencer with a scoreboard of expected instr_pc
// values and a behavioural single-cycle memory holding 0xA0+index.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;
  import fetch_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [31:0] expQ [$];
  logic [31:0] memWords [16];
  logic [31:0] expPc;

  fetch_sequencer_if bus ();

  fetch_sequencer #(
    .RESET_PC   (32'd0),
    .PROG_WORDS (7),
    .ADDR_STEP  (32'd1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .fetchBus (bus)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-cycle-latency memory: samples mem_addr on each rising edge.
  always @(posedge clk) begin
    if (bus.mem_addr < 32'd16) bus.mem_rdata <= memWords[bus.mem_addr[3:0]];
    else                       bus.mem_rdata <= 32'hDEAD_BEEF;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive all control inputs, then let one rising edge sample them.
  task automatic applyStimulus(input logic st, input logic sl, input logic rv,
                               input logic [31:0] rpc, input logic rdy);
    bus.start          = st;
    bus.stall          = sl;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.instr_ready    = rdy;
    tick();
  endtask

  task automatic pushProgram(input int first, input int last);
    for (int i = first; i <= last; i++) expQ.push_back(32'(i));
  endtask

  task automatic waitHalted(input string name);
    int n = 0;
    while (!bus.halted && n < 40) begin
      tick();
      n++;
    end
    checkOutput(name, 32'(bus.halted), 32'd1);
    checkOutput({name, "_busy"}, 32'(bus.busy), 32'd0);
    checkOutput({name, "_drained"}, 32'(expQ.size()), 32'd0);
  endtask

  // Monitor: every accepted transfer must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && bus.instr_valid && bus.instr_ready) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_instr actual_pc=0x%08h required=none", bus.instr_pc);
      end else begin
        expPc = expQ.pop_front();
        checkOutput("instr_pc", bus.instr_pc, expPc);
        checkOutput("instr", bus.instr, 32'hA0 + expPc);
      end
    end
  end

  // Global watchdog.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 16; i++) memWords[i] = 32'hA0 + 32'(i);
    bus.start          = 1'b0;
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.instr_ready    = 1'b0;
    rst_n              = 1'b0;

    // Reset state.
    tick();
    tick();
    checkOutput("rst_valid", 32'(bus.instr_valid), 32'd0);
    checkOutput("rst_addr", bus.mem_addr, 32'd0);
    checkOutput("rst_instr", bus.instr, 32'd0);
    checkOutput("rst_instr_pc", bus.instr_pc, 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_halted", 32'(bus.halted), 32'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("idle_busy", 32'(bus.busy), 32'd0);

    // Straight-line run, decode always ready.
    $display("[TB] full program run");
    pushProgram(0, 6);
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t1_latency_early", 32'(bus.instr_valid), 32'd0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t1_first_valid", 32'(bus.instr_valid), 32'd1);
    checkOutput("t1_first_pc", bus.instr_pc, 32'd0);
    waitHalted("t1_halt");
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("t1_no_valid_after_halt", 32'(bus.instr_valid), 32'd0);
    end

    // Decode backpressure from the second instruction.
    $display("[TB] backpressure");
    pushProgram(0, 6);
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    bus.instr_ready = 1'b0;
    checkOutput("t2_hold_pc", bus.instr_pc, 32'd1);
    checkOutput("t2_addr", bus.mem_addr, 32'd3);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("t2_hold_valid", 32'(bus.instr_valid), 32'd1);
      checkOutput("t2_hold_pc", bus.instr_pc, 32'd1);
      checkOutput("t2_addr_frozen", bus.mem_addr, 32'd3);
    end
    bus.instr_ready = 1'b1;
    waitHalted("t2_halt");

    // Stall for three cycles after two fetches were issued.
    $display("[TB] stall");
    pushProgram(0, 6);
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 1);
    checkOutput("t3_inflight_delivered", bus.instr_pc, 32'd1);
    checkOutput("t3_stall_addr", bus.mem_addr, 32'd2);
    applyStimulus(0, 1, 0, 0, 1);
    checkOutput("t3_stall_addr", bus.mem_addr, 32'd2);
    applyStimulus(0, 1, 0, 0, 1);
    checkOutput("t3_stall_addr", bus.mem_addr, 32'd2);
    checkOutput("t3_stall_empty", 32'(bus.instr_valid), 32'd0);
    bus.stall = 1'b0;
    waitHalted("t3_halt");

    // Redirect to 5 while pc 2 is buffered and pc 3 is in flight.
    $display("[TB] redirect in range");
    expQ.push_back(32'd0);
    expQ.push_back(32'd1);
    pushProgram(5, 6);
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t4_pre_redirect_pc", bus.instr_pc, 32'd2);
    applyStimulus(0, 0, 1, 32'd5, 0);
    checkOutput("t4_flushed", 32'(bus.instr_valid), 32'd0);
    checkOutput("t4_addr", bus.mem_addr, 32'd5);
    bus.redirect_valid = 1'b0;
    bus.instr_ready    = 1'b1;
    waitHalted("t4_halt");

    // Redirect beyond the program end.
    $display("[TB] redirect out of range");
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t5_valid_before", 32'(bus.instr_valid), 32'd1);
    applyStimulus(0, 0, 1, 32'd9, 0);
    checkOutput("t5_drain_busy", 32'(bus.busy), 32'd1);
    checkOutput("t5_drain_not_halted", 32'(bus.halted), 32'd0);
    checkOutput("t5_flushed", 32'(bus.instr_valid), 32'd0);
    checkOutput("t5_addr", bus.mem_addr, 32'd9);
    bus.redirect_valid = 1'b0;
    bus.instr_ready    = 1'b1;
    tick();
    checkOutput("t5_halted", 32'(bus.halted), 32'd1);
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput("t5_no_valid", 32'(bus.instr_valid), 32'd0);
    end

    // Asynchronous reset mid-run while an instruction is presented.
    $display("[TB] async reset");
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t6_valid_before", 32'(bus.instr_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_async_valid", 32'(bus.instr_valid), 32'd0);
    checkOutput("t6_async_addr", bus.mem_addr, 32'd0);
    checkOutput("t6_async_busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    tick();
    checkOutput("t6_idle_busy", 32'(bus.busy), 32'd0);
    checkOutput("t6_idle_halted", 32'(bus.halted), 32'd0);
    pushProgram(0, 6);
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t6_restart_pc", bus.instr_pc, 32'd0);
    waitHalted("t6_halt");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
